// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM encoding and reference feedback masks shared by lfsr_gen.
// Tap masks follow the shift rule fb = ^(state & TAPS), state = {fb, state[W-1:1]};
// each mask below gives a maximal-length sequence for its width.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } lfsr_state_e;

    localparam logic [7:0]  TAPS_W8  = 8'h71;
    localparam logic [15:0] TAPS_W16 = 16'h002D;
    localparam logic [31:0] TAPS_W32 = 32'h0040_0007;

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: purely combinational STEP-fold of the single-shift LFSR rule.
// The shifts are chained so one clock cycle can retire STEP output bits.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16),
    parameter int               STEP  = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] s;

    // Unrolled chain of STEP shifts: feedback enters at the MSB, bit 0 falls out.
    always_comb begin
        s = state_i;
        for (int i = 0; i < STEP; i++) begin
            s = {^(s & TAPS), s[WIDTH-1:1]};
        end
        state_o = s;
    end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR word generator with warm-up, reseed and a
// valid/ready output. Optional period tracking (period_wrap / period_len)
// is compiled in when LFSR_GEN_PERIOD_CNT_EN is defined.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_W16),
    parameter logic [WIDTH-1:0] SEED   = '1,
    parameter int               STEP   = 1,
    parameter int               WARMUP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [STEP-1:0]  dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] state_o,
    output logic             busy,
    output logic             seed_fix
`ifdef LFSR_GEN_PERIOD_CNT_EN
    ,
    output logic             period_wrap,
    output logic [WIDTH-1:0] period_len
`endif
);

    localparam bit         HAS_WARMUP = (WARMUP != 0);
    localparam logic [7:0] WU_LAST    = HAS_WARMUP ? 8'(WARMUP - 1) : 8'd0;

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             seed_fix_q, seed_fix_d;
    logic [WIDTH-1:0] step_nxt, adv_state, load_val;
    logic             advance;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(STEP)) u_step (
        .state_i (state_q),
        .state_o (step_nxt)
    );

    // A zero seed would lock the register, so it is swapped for SEED; the
    // same substitution guards the advance path against ever reaching zero.
    assign load_val  = (seed_in == '0) ? SEED : seed_in;
    assign adv_state = (step_nxt == '0) ? SEED : step_nxt;

    // State register: FSM, LFSR state, warm-up counter, seed-fix pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= ST_IDLE;
            state_q    <= SEED;
            wcnt_q     <= '0;
            seed_fix_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            seed_fix_q <= seed_fix_d;
        end
    end

    // Next-state logic; load overrides whatever the current state wants.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:   if (en) fsm_d = HAS_WARMUP ? ST_WARMUP : ST_RUN;
            ST_WARMUP: if (wcnt_q == WU_LAST) fsm_d = ST_RUN;
            ST_RUN:    if (!en && out_ready) fsm_d = ST_IDLE;
            default:   fsm_d = ST_IDLE;
        endcase
        if (load) fsm_d = en ? (HAS_WARMUP ? ST_WARMUP : ST_RUN) : ST_IDLE;
    end

    // Outputs decoded from the current state; advance on warm-up or handshake.
    always_comb begin
        out_valid = (fsm_q == ST_RUN);
        busy      = (fsm_q == ST_WARMUP);
        advance   = busy || (out_valid && out_ready);
    end

    // Datapath: reseed, advance, and the warm-up count (zero outside warm-up).
    always_comb begin
        state_d    = state_q;
        seed_fix_d = 1'b0;
        wcnt_d     = (fsm_q == ST_WARMUP && fsm_d == ST_WARMUP && !load) ? wcnt_q + 8'd1 : 8'd0;
        if (load) begin
            state_d    = load_val;
            seed_fix_d = (seed_in == '0);
        end else if (advance) begin
            state_d = adv_state;
        end
    end

    assign dout     = state_q[STEP-1:0];
    assign state_o  = state_q;
    assign seed_fix = seed_fix_q;

`ifdef LFSR_GEN_PERIOD_CNT_EN
    logic [WIDTH-1:0] ref_q, ref_d, pcnt_q, pcnt_d, plen_q, plen_d;
    logic             pwrap_q, pwrap_d;

    // Period tracker registers: reference point, running count, last period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q   <= SEED;
            pcnt_q  <= '0;
            plen_q  <= '0;
            pwrap_q <= 1'b0;
        end else begin
            ref_q   <= ref_d;
            pcnt_q  <= pcnt_d;
            plen_q  <= plen_d;
            pwrap_q <= pwrap_d;
        end
    end

    // Count advances since the reference; closing the loop latches the length.
    always_comb begin
        ref_d   = ref_q;
        pcnt_d  = pcnt_q;
        plen_d  = plen_q;
        pwrap_d = 1'b0;
        if (load) begin
            ref_d  = load_val;
            pcnt_d = '0;
        end else if (advance) begin
            if (adv_state == ref_q) begin
                pwrap_d = 1'b1;
                plen_d  = pcnt_q + WIDTH'(1);
                pcnt_d  = '0;
            end else begin
                pcnt_d = pcnt_q + WIDTH'(1);
            end
        end
    end

    assign period_wrap = pwrap_q;
    assign period_len  = plen_q;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen.
// Three instances: A = defaults, B = STEP 8 / WARMUP 4, C = 8-bit TAPS 8'h71.
// The reference is the full 16-bit m-sequence held as a table (seq / idx):
// "n advances from s" is seq[(idx[s] + n) % P], and a STEP-8 word is eight
// consecutive LSBs of that serial stream.
module tb_lfsr_gen;

    localparam int P = 65535;
    typedef struct packed { logic [15:0] st; logic [7:0] d; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] seq [0:P-1];
    int          idx [0:65535];
    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  qc[$];
    int          pa = 0;
    int          pb = 0;

    // DUT A: defaults
    logic a_en = 0, a_load = 0, a_ready = 0;
    logic [15:0] a_seed = '0, a_state;
    logic [0:0] a_dout;
    logic a_valid, a_busy, a_fix;
    // DUT B: STEP 8, WARMUP 4
    logic b_en = 0, b_load = 0, b_ready = 0;
    logic [15:0] b_seed = '0, b_state;
    logic [7:0] b_dout;
    logic b_valid, b_busy, b_fix;
    // DUT C: 8-bit
    logic c_en = 0, c_load = 0, c_ready = 0;
    logic [7:0] c_seed = '0, c_state;
    logic [0:0] c_dout;
    logic c_valid, c_busy, c_fix;
`ifdef LFSR_GEN_PERIOD_CNT_EN
    logic a_wrap, b_wrap, c_wrap;
    logic [15:0] a_plen, b_plen;
    logic [7:0] c_plen;
    int a_wraps = 0, b_wraps = 0, c_wraps = 0;
`endif

    lfsr_gen dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .load(a_load), .seed_in(a_seed),
        .dout(a_dout), .out_valid(a_valid), .out_ready(a_ready), .state_o(a_state),
        .busy(a_busy), .seed_fix(a_fix)
`ifdef LFSR_GEN_PERIOD_CNT_EN
        , .period_wrap(a_wrap), .period_len(a_plen)
`endif
    );

    lfsr_gen #(.WIDTH(16), .STEP(8), .WARMUP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .load(b_load), .seed_in(b_seed),
        .dout(b_dout), .out_valid(b_valid), .out_ready(b_ready), .state_o(b_state),
        .busy(b_busy), .seed_fix(b_fix)
`ifdef LFSR_GEN_PERIOD_CNT_EN
        , .period_wrap(b_wrap), .period_len(b_plen)
`endif
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h71), .SEED(8'hFF), .STEP(1), .WARMUP(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .load(c_load), .seed_in(c_seed),
        .dout(c_dout), .out_valid(c_valid), .out_ready(c_ready), .state_o(c_state),
        .busy(c_busy), .seed_fix(c_fix)
`ifdef LFSR_GEN_PERIOD_CNT_EN
        , .period_wrap(c_wrap), .period_len(c_plen)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard producers ----------------
    task automatic push_a(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.st = seq[(pa + i) % P];
            e.d  = {7'd0, e.st[0]};
            qa.push_back(e);
        end
        pa = (pa + n) % P;
    endtask

    task automatic push_b(input int n);
        exp_t e;
        int p;
        for (int i = 0; i < n; i++) begin
            p = (pb + 8 * i) % P;
            e.st = seq[p];
            for (int j = 0; j < 8; j++) e.d[j] = seq[(p + j) % P][0];
            qb.push_back(e);
        end
        pb = (pb + 8 * n) % P;
    endtask

    task automatic a_drain(input int pct);
        int budget;
        int c;
        budget = (pct >= 100) ? qa.size() + 20 : qa.size() * 40 + 50;
        c = 0;
        while (qa.size() > 0 && c < budget) begin
            a_ready = ($urandom_range(99) < pct);
            tick();
            c++;
        end
        a_ready = 1'b0;
        if (qa.size() > 0) begin
            checks++; errors++;
            $display("FAIL a_drain_timeout left %0d required 0", qa.size());
            qa.delete();
        end
    endtask

    task automatic b_drain(input int pct);
        int budget;
        int c;
        budget = qb.size() * 40 + 50;
        c = 0;
        while (qb.size() > 0 && c < budget) begin
            b_ready = ($urandom_range(99) < pct);
            tick();
            c++;
        end
        b_ready = 1'b0;
        if (qb.size() > 0) begin
            checks++; errors++;
            $display("FAIL b_drain_timeout left %0d required 0", qb.size());
            qb.delete();
        end
    endtask

    task automatic a_load_seed(input logic [15:0] s, input logic e);
        logic [15:0] eff;
        eff = (s == 16'h0) ? 16'hFFFF : s;
        a_seed = s; a_load = 1'b1; a_en = e; a_ready = 1'b0;
        tick();
        a_load = 1'b0;
        chk("a_load_state", 32'(a_state), 32'(eff));
        chk("a_seed_fix", 32'(a_fix), 32'(s == 16'h0));
        chk("a_valid_after_load", 32'(a_valid), 32'(e));
        pa = idx[eff];
        tick();
        chk("a_seed_fix_clear", 32'(a_fix), 32'd0);
    endtask

    // Counts the warm-up window from the current sample; expects exactly 4.
    task automatic b_wait_warm();
        int cnt;
        cnt = 0;
        while (b_busy && cnt < 20) begin
            if (b_valid) begin
                checks++; errors++;
                $display("FAIL b_valid_in_warmup got 1 required 0");
            end
            cnt++;
            tick();
        end
        chk("b_warmup_len", 32'(cnt), 32'd4);
        chk("b_valid_after_warm", 32'(b_valid), 32'd1);
        chk("b_state_after_warm", 32'(b_state), 32'(seq[pb]));
    endtask

    task automatic b_load_seed(input logic [15:0] s, input logic e);
        logic [15:0] eff;
        eff = (s == 16'h0) ? 16'hFFFF : s;
        b_seed = s; b_load = 1'b1; b_en = e; b_ready = 1'b0;
        tick();
        b_load = 1'b0;
        chk("b_load_state", 32'(b_state), 32'(eff));
        chk("b_valid_retract", 32'(b_valid), 32'd0);
        chk("b_busy_after_load", 32'(b_busy), 32'(e));
        chk("b_seed_fix", 32'(b_fix), 32'(s == 16'h0));
        pb = idx[eff];
        if (!e) begin
            tick();
            chk("b_idle_hold", 32'(b_state), 32'(eff));
            b_en = 1'b1;
            tick();
        end
        pb = (pb + 32) % P;
        b_wait_warm();
    endtask

    // ---------------- monitors ----------------
    exp_t        ea, eb;
    logic        a_stall = 0, b_stall = 0, a_zero = 0;
    logic [15:0] a_hs, b_hs;
    logic [0:0]  a_hd;
    logic [7:0]  b_hd;
    int          c_acc = 0;
    logic [7:0]  ec;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_state == 16'h0) a_zero = 1'b1;
            if (a_stall) begin
                checks++;
                if (!a_valid || a_state !== a_hs || a_dout !== a_hd) begin
                    errors++;
                    $display("FAIL a_stall_hold got v=%b st=%h d=%b required v=1 st=%h d=%b",
                             a_valid, a_state, a_dout, a_hs, a_hd);
                end
            end
            a_stall = a_valid && !a_ready && !a_load;
            a_hs = a_state;
            a_hd = a_dout;
            if (a_valid && a_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_accept got st=%h required no accept", a_state);
                end else begin
                    ea = qa.pop_front();
                    if (a_state !== ea.st || a_dout !== ea.d[0]) begin
                        errors++;
                        $display("FAIL a_word got st=%h d=%b required st=%h d=%b",
                                 a_state, a_dout, ea.st, ea.d[0]);
                    end
                end
            end
`ifdef LFSR_GEN_PERIOD_CNT_EN
            if (a_wrap) a_wraps++;
            if (b_wrap) b_wraps++;
            if (c_wrap) c_wraps++;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_stall) begin
                checks++;
                if (!b_valid || b_state !== b_hs || b_dout !== b_hd) begin
                    errors++;
                    $display("FAIL b_stall_hold got v=%b st=%h d=%h required v=1 st=%h d=%h",
                             b_valid, b_state, b_dout, b_hs, b_hd);
                end
            end
            b_stall = b_valid && !b_ready && !b_load;
            b_hs = b_state;
            b_hd = b_dout;
            if (b_valid && b_ready) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_accept got st=%h required no accept", b_state);
                end else begin
                    eb = qb.pop_front();
                    if (b_state !== eb.st || b_dout !== eb.d) begin
                        errors++;
                        $display("FAIL b_word got st=%h d=%h required st=%h d=%h",
                                 b_state, b_dout, eb.st, eb.d);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && c_valid && c_ready) begin
            c_acc++;
            if (qc.size() > 0) begin
                ec = qc.pop_front();
                checks++;
                if (c_state !== ec) begin
                    errors++;
                    $display("FAIL c_sequence got %h required %h", c_state, ec);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] s;
        logic        e;
        int          n;
`ifdef LFSR_GEN_PERIOD_CNT_EN
        logic [15:0] b_plen0;
`endif
        s = 16'hFFFF;
        for (int k = 0; k < P; k++) begin
            seq[k] = s;
            idx[s] = k;
            s = {^(s & 16'h002D), s[15:1]};
        end

        #12;
        chk("rst_a_state", 32'(a_state), 32'hFFFF);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_fix", 32'(a_fix), 32'd0);
        chk("rst_b_state", 32'(b_state), 32'hFFFF);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_c_state", 32'(c_state), 32'hFF);
`ifdef LFSR_GEN_PERIOD_CNT_EN
        chk("rst_a_wrap", 32'(a_wrap), 32'd0);
        chk("rst_c_wrap", 32'(c_wrap), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 8-bit sequence FF,7F,3F,9F then the full 255-long period
        qc.push_back(8'hFF); qc.push_back(8'h7F); qc.push_back(8'h3F); qc.push_back(8'h9F);
        c_en = 1'b1; c_ready = 1'b1;
        n = 0;
        while (c_acc < 255 && n < 300) begin tick(); n++; end
        c_ready = 1'b0;
        chk("c_accepts", 32'(c_acc), 32'd255);
        chk("c_period_state", 32'(c_state), 32'hFF);
        chk("c_seq_drained", 32'(qc.size()), 32'd0);
        tick();
`ifdef LFSR_GEN_PERIOD_CNT_EN
        chk("c_wraps", 32'(c_wraps), 32'd1);
        chk("c_period_len", 32'(c_plen), 32'd255);
`endif

        // Full 16-bit period on the default instance
        a_en = 1'b1;
        pa = 0;
        push_a(P);
        a_drain(100);
        tick();
        chk("a_period_state", 32'(a_state), 32'hFFFF);
        chk("a_no_zero_state", 32'(a_zero), 32'd0);
`ifdef LFSR_GEN_PERIOD_CNT_EN
        chk("a_wraps", 32'(a_wraps), 32'd1);
        chk("a_period_len", 32'(a_plen), 32'd65535);
`endif

        // Five-cycle stall after a reseed, then drain
        a_load_seed(16'h1234, 1'b1);
        repeat (5) tick();
        chk("a_valid_in_stall", 32'(a_valid), 32'd1);
        push_a(3);
        a_drain(100);

        // en falls in RUN: stays valid until one word is accepted, then idles
        a_en = 1'b0;
        repeat (3) tick();
        chk("a_valid_en_low_stall", 32'(a_valid), 32'd1);
        push_a(1);
        a_drain(100);
        chk("a_idle_after_drop", 32'(a_valid), 32'd0);
        chk("a_idle_state", 32'(a_state), 32'(seq[pa]));
        repeat (3) tick();
        chk("a_idle_hold", 32'(a_state), 32'(seq[pa]));
        a_en = 1'b1;
        tick();
        chk("a_rerun_valid", 32'(a_valid), 32'd1);
        push_a(4);
        a_drain(60);

        // Randomised reseed segments
        for (int seg = 0; seg < 20; seg++) begin
            s = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            e = ($urandom_range(3) != 0);
            a_load_seed(s, e);
            if (!e) begin
                a_en = 1'b1;
                tick();
            end
            push_a($urandom_range(16, 1));
            a_drain($urandom_range(100, 20));
        end

        // STEP 8 / WARMUP 4 instance
`ifdef LFSR_GEN_PERIOD_CNT_EN
        b_plen0 = b_plen;
`endif
        b_en = 1'b1;
        tick();
        chk("b_busy_on_start", 32'(b_busy), 32'd1);
        pb = 32;
        b_wait_warm();
        push_b(6);
        b_drain(70);
        for (int seg = 0; seg < 8; seg++) begin
            s = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            e = ($urandom_range(3) != 0);
            b_load_seed(s, e);
            push_b($urandom_range(10, 1));
            b_drain($urandom_range(100, 30));
        end
`ifdef LFSR_GEN_PERIOD_CNT_EN
        chk("b_no_wrap", 32'(b_wraps), 32'd0);
        chk("b_plen_held", 32'(b_plen), 32'(b_plen0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
